// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE control sequencer: FSM states, ctrl word
// field sizes, src_2 select values and MACC op codes.
package pe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_DRAIN,
      ST_FLUSH,
      ST_FLUSH_DRAIN,
      ST_DONE
   } state_e;

   // Single-bit flags between op_code and the address fields:
   // {flush, write_valid, write_req, read_req, enable}
   localparam int unsigned CTRL_FLAG_BITS = 5;
   // {norm_push, norm_pop} at the top of the word
   localparam int unsigned CTRL_NORM_BITS = 2;
   localparam logic [1:0]  NORM_IDLE      = 2'b00;

   localparam logic SRC_2_BIAS = 1'b1;
   localparam logic SRC_2_BUF  = 1'b0;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_MACC      = 3'd1;
   localparam logic [2:0] OP_MACC_RELU = 3'd2;

   function automatic int unsigned ctrl_bits(input int unsigned addr_w,
                                             input int unsigned op_w);
      return CTRL_NORM_BITS + 2 * addr_w + CTRL_FLAG_BITS + op_w;
   endfunction

endpackage

// File: rtl/pe_ctrl_sequencer_delay.sv
// Fixed-depth register delay line with asynchronous clear; advances every cycle.
module pe_ctrl_sequencer_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Next value of each stage: input into stage 0, then shift by one.
   always_comb begin
      stage_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers, cleared on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// Layer-level controller for a PE array: accumulate passes, drain, flush
// pass, flush drain, one-cycle done. All outputs are registered.
module pe_ctrl_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int PE_BUF_ADDR_WIDTH = 10,
   parameter int OP_CODE_WIDTH     = 3,
   parameter int CNT_WIDTH         = 12,
   parameter int MACC_LAT          = 3,
   parameter int FLUSH_LAT         = 3,
   parameter int CTRL_WIDTH        = 10 + 2 * PE_BUF_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_num_out,
   input  logic [CNT_WIDTH-1:0]         cfg_num_acc,
   input  logic [OP_CODE_WIDTH-1:0]     cfg_op_code,
   input  logic                         stall,
   output logic [CTRL_WIDTH-1:0]        ctrl,
   output logic                         src_2_sel,
   output logic                         busy,
   output logic                         done
);

   localparam int AW       = PE_BUF_ADDR_WIDTH;
   localparam int LAT_MAX  = (MACC_LAT > FLUSH_LAT) ? MACC_LAT : FLUSH_LAT;
   localparam int LAT_W    = $clog2(LAT_MAX + 1);
   localparam int CTRL_BITS = ctrl_bits(PE_BUF_ADDR_WIDTH, OP_CODE_WIDTH);

   state_e                 state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [CNT_WIDTH-1:0]   pass_q, pass_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [AW-1:0]          num_out_q, num_out_d;
   logic [CNT_WIDTH-1:0]   num_acc_q, num_acc_d;
   logic [OP_CODE_WIDTH-1:0] op_cfg_q, op_cfg_d;

   logic                   enable_q, enable_d;
   logic                   read_req_q, read_req_d;
   logic                   flush_q, flush_d;
   logic [AW-1:0]          rd_addr_q, rd_addr_d;
   logic [OP_CODE_WIDTH-1:0] op_code_q, op_code_d;
   logic                   src_2_sel_q, src_2_sel_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [AW:0]            wb_din, wb_dout;
   logic                   write_req, write_valid;
   logic [AW-1:0]          wr_addr;
   logic [CTRL_BITS-1:0]   ctrl_packed;

   // Next-state, counter and issue decisions for the following cycle.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pass_d      = pass_q;
      lat_d       = lat_q;
      num_out_d   = num_out_q;
      num_acc_d   = num_acc_q;
      op_cfg_d    = op_cfg_q;
      enable_d    = 1'b0;
      read_req_d  = 1'b0;
      flush_d     = 1'b0;
      rd_addr_d   = '0;
      op_code_d   = OP_CODE_WIDTH'(OP_NOP);
      src_2_sel_d = SRC_2_BUF;
      done_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_COMPUTE;
               num_out_d = cfg_num_out;
               num_acc_d = cfg_num_acc;
               op_cfg_d  = cfg_op_code;
               addr_d    = '0;
               pass_d    = '0;
            end
         end
         ST_COMPUTE: begin
            if (!stall) begin
               enable_d    = 1'b1;
               read_req_d  = 1'b1;
               rd_addr_d   = addr_q;
               op_code_d   = op_cfg_q;
               src_2_sel_d = (pass_q == '0) ? SRC_2_BIAS : SRC_2_BUF;
               if (addr_q == num_out_q) begin
                  addr_d = '0;
                  if (pass_q == num_acc_q) begin
                     state_d = ST_DRAIN;
                     lat_d   = '0;
                  end else begin
                     pass_d = pass_q + 1'b1;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (lat_q == LAT_W'(MACC_LAT - 1)) begin
               state_d = ST_FLUSH;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               read_req_d = 1'b1;
               flush_d    = 1'b1;
               rd_addr_d  = addr_q;
               if (addr_q == num_out_q) begin
                  state_d = ST_FLUSH_DRAIN;
                  addr_d  = '0;
                  lat_d   = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_FLUSH_DRAIN: begin
            // Counts one past FLUSH_LAT so done lands the cycle after the
            // last write_valid rather than alongside it.
            if (lat_q == LAT_W'(FLUSH_LAT)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM, counters, latched config and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         pass_q      <= '0;
         lat_q       <= '0;
         num_out_q   <= '0;
         num_acc_q   <= '0;
         op_cfg_q    <= '0;
         enable_q    <= 1'b0;
         read_req_q  <= 1'b0;
         flush_q     <= 1'b0;
         rd_addr_q   <= '0;
         op_code_q   <= '0;
         src_2_sel_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pass_q      <= pass_d;
         lat_q       <= lat_d;
         num_out_q   <= num_out_d;
         num_acc_q   <= num_acc_d;
         op_cfg_q    <= op_cfg_d;
         enable_q    <= enable_d;
         read_req_q  <= read_req_d;
         flush_q     <= flush_d;
         rd_addr_q   <= rd_addr_d;
         op_code_q   <= op_code_d;
         src_2_sel_q <= src_2_sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Write-back line carries only compute issues; address zeroed on bubbles.
   always_comb begin
      wb_din = {enable_q, (enable_q ? rd_addr_q : {AW{1'b0}})};
   end

   pe_ctrl_sequencer_delay #(
      .WIDTH (AW + 1),
      .DEPTH (MACC_LAT)
   ) u_wb_line (
      .clk   (clk),
      .reset (reset),
      .din   (wb_din),
      .dout  (wb_dout)
   );

   pe_ctrl_sequencer_delay #(
      .WIDTH (1),
      .DEPTH (FLUSH_LAT)
   ) u_wv_line (
      .clk   (clk),
      .reset (reset),
      .din   (flush_q),
      .dout  (write_valid)
   );

   always_comb begin
      write_req   = wb_dout[AW];
      wr_addr     = wb_dout[AW-1:0];
      ctrl_packed = {NORM_IDLE, rd_addr_q, wr_addr, flush_q, write_valid,
                     write_req, read_req_q, enable_q, op_code_q};
   end

   assign ctrl      = CTRL_WIDTH'(ctrl_packed);
   assign src_2_sel = src_2_sel_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Self-checking bench for pe_ctrl_sequencer: per-cycle compare against a
// timeline model built from the sequencing rules, plus literal pins.
module tb_pe_ctrl_sequencer;
   import pe_ctrl_pkg::*;

   localparam int AW   = 10;
   localparam int CW   = 12;
   localparam int OPW  = 3;
   localparam int ML   = 3;
   localparam int FL   = 3;
   localparam int CTW  = 10 + 2 * AW;
   localparam int MAXC = 3300;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          en;
      logic          rd;
      logic          wreq;
      logic          wv;
      logic          fl;
      logic          src2;
      logic [2:0]    op;
      logic [AW-1:0] rdaddr;
      logic [AW-1:0] waddr;
      logic [1:0]    norm;
   } obs_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [AW-1:0]  cfg_num_out = '0;
   logic [CW-1:0]  cfg_num_acc = '0;
   logic [OPW-1:0] cfg_op_code = '0;
   logic           stall = 1'b0;
   logic [CTW-1:0] ctrl;
   logic           src_2_sel;
   logic           busy;
   logic           done;

   obs_t exp_q [MAXC];
   bit   stall_sched [MAXC];
   int   total = 0;
   int   bad = 0;
   int   cyc;
   int   obs_first_done, obs_wreq, obs_wv, obs_top;

   always #5 clk = ~clk;

   pe_ctrl_sequencer #(
      .PE_BUF_ADDR_WIDTH (AW),
      .OP_CODE_WIDTH     (OPW),
      .CNT_WIDTH         (CW),
      .MACC_LAT          (ML),
      .FLUSH_LAT         (FL),
      .CTRL_WIDTH        (CTW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_num_out (cfg_num_out),
      .cfg_num_acc (cfg_num_acc),
      .cfg_op_code (cfg_op_code),
      .stall       (stall),
      .ctrl        (ctrl),
      .src_2_sel   (src_2_sel),
      .busy        (busy),
      .done        (done)
   );

   function automatic obs_t sample();
      obs_t o;
      o.busy   = busy;
      o.done   = done;
      o.op     = ctrl[2:0];
      o.en     = ctrl[3];
      o.rd     = ctrl[4];
      o.wreq   = ctrl[5];
      o.wv     = ctrl[6];
      o.fl     = ctrl[7];
      o.waddr  = ctrl[17:8];
      o.rdaddr = ctrl[27:18];
      o.norm   = ctrl[29:28];
      o.src2   = src_2_sel;
      return o;
   endfunction

   // Timeline model: cycle n is the window after the n-th edge following the
   // edge that accepted start. Returns the done cycle.
   function automatic int build_model(input int n_out, input int n_acc,
                                      input logic [2:0] op);
      int t;
      int done_t;
      for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
      t = 1;
      for (int p = 0; p <= n_acc; p++) begin
         for (int a = 0; a <= n_out; a++) begin
            while (stall_sched[t]) t++;
            exp_q[t].en     = 1'b1;
            exp_q[t].rd     = 1'b1;
            exp_q[t].op     = op;
            exp_q[t].rdaddr = AW'(a);
            exp_q[t].src2   = (p == 0);
            exp_q[t + ML].wreq  = 1'b1;
            exp_q[t + ML].waddr = AW'(a);
            t++;
         end
      end
      t = (t - 1) + ML + 1;
      for (int a = 0; a <= n_out; a++) begin
         while (stall_sched[t]) t++;
         exp_q[t].rd     = 1'b1;
         exp_q[t].fl     = 1'b1;
         exp_q[t].rdaddr = AW'(a);
         exp_q[t + FL].wv = 1'b1;
         t++;
      end
      done_t = (t - 1) + FL + 1;
      for (int i = 0; i <= done_t; i++) exp_q[i].busy = 1'b1;
      exp_q[done_t].done = 1'b1;
      return done_t;
   endfunction

   task automatic check(input string name, input int c, input logic [63:0] act,
                        input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
      end
   endtask

   task automatic clear_stalls();
      for (int i = 0; i < MAXC; i++) stall_sched[i] = 1'b0;
   endtask

   // Runs one layer; per-cycle compare until done+1 or until abort_at.
   task automatic run_layer(input string name, input int n_out, input int n_acc,
                            input logic [2:0] op, input bit hold_start,
                            input int abort_at);
      int   done_t;
      int   last;
      obs_t o;
      done_t = build_model(n_out, n_acc, op);
      last   = (abort_at > 0) ? abort_at : done_t + 1;
      @(posedge clk); #1;
      start = 1'b1;
      cfg_num_out = AW'(n_out);
      cfg_num_acc = CW'(n_acc);
      cfg_op_code = op;
      stall = 1'b0;
      @(posedge clk); #1;
      cyc = 0;
      obs_first_done = -1;
      obs_wreq = 0;
      obs_wv = 0;
      obs_top = 0;
      while (1) begin
         stall = stall_sched[cyc + 1];
         if (hold_start) begin
            start = (cyc < done_t);
            cfg_num_out = AW'($urandom);
            cfg_num_acc = CW'($urandom_range(0, 7));
            cfg_op_code = OPW'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         o = sample();
         check(name, cyc, 64'(o), 64'(exp_q[cyc]));
         if (o.done && obs_first_done < 0) obs_first_done = cyc;
         if (o.wreq) obs_wreq++;
         if (o.wv) obs_wv++;
         if (o.wreq && o.waddr == AW'(1023)) obs_top++;
         if (cyc == last) break;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      clear_stalls();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 0, 64'({ctrl, src_2_sel, busy, done}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 0, 64'({ctrl, src_2_sel, busy, done}), 64'(0));

      // Basic two-pass layer
      run_layer("t1_basic", 3, 1, OP_MACC, 1'b0, 0);
      check("t1_done_cycle", 0, 64'(obs_first_done), 64'(19));
      check("t1_wreq_count", 0, 64'(obs_wreq), 64'(8));
      check("t1_wv_count", 0, 64'(obs_wv), 64'(4));

      // Two stall cycles at second-pass a=1 (issue would be cycle 6)
      clear_stalls();
      stall_sched[6] = 1'b1;
      stall_sched[7] = 1'b1;
      run_layer("t2_stall", 3, 1, OP_MACC, 1'b0, 0);
      check("t2_done_cycle", 0, 64'(obs_first_done), 64'(21));
      check("t2_wreq_count", 0, 64'(obs_wreq), 64'(8));
      clear_stalls();

      // Degenerate: one neuron, single bias pass
      run_layer("t3_min", 0, 0, OP_MACC_RELU, 1'b0, 0);
      check("t3_done_cycle", 0, 64'(obs_first_done), 64'(9));
      check("t3_wreq_count", 0, 64'(obs_wreq), 64'(1));
      check("t3_wv_count", 0, 64'(obs_wv), 64'(1));

      // start held high and cfg churned mid-layer
      run_layer("t4_hold_start", 3, 1, OP_MACC, 1'b1, 0);
      check("t4_done_cycle", 0, 64'(obs_first_done), 64'(19));

      // Compute stall, ignored drain stall, flush stall
      stall_sched[3]  = 1'b1;
      stall_sched[18] = 1'b1;
      stall_sched[21] = 1'b1;
      run_layer("t5_mixed_stall", 4, 2, OP_MACC_RELU, 1'b0, 0);
      check("t5_done_cycle", 0, 64'(obs_first_done), 64'(29));
      check("t5_wv_count", 0, 64'(obs_wv), 64'(5));
      clear_stalls();

      // Reset mid-compute aborts the layer
      run_layer("t6_pre_abort", 3, 1, OP_MACC, 1'b0, 5);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_clear", 0, 64'({ctrl, src_2_sel, busy, done}), 64'(0));
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t6_no_done", i, 64'({ctrl, src_2_sel, busy, done}), 64'(0));
      end
      run_layer("t6_clean", 3, 1, OP_MACC, 1'b0, 0);
      check("t6_done_cycle", 0, 64'(obs_first_done), 64'(19));

      // Full address range, two passes
      run_layer("t7_full", 1023, 1, OP_MACC, 1'b0, 0);
      check("t7_done_cycle", 0, 64'(obs_first_done), 64'(3079));
      check("t7_top_addr_writes", 0, 64'(obs_top), 64'(2));
      check("t7_wreq_count", 0, 64'(obs_wreq), 64'(2048));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
